// File: rtl/axi_arb_pkg.sv
// Shared constants for the two-requester AXI burst arbiter: burst types,
// FSM encoding, response codes and the command legality check.
package axi_arb_pkg;

   localparam logic [1:0] BT_FIXED = 2'd0;
   localparam logic [1:0] BT_INCR  = 2'd1;
   localparam logic [1:0] BT_WRAP  = 2'd2;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARB   = 3'd1;
   localparam logic [2:0] S_WBEAT = 3'd2;
   localparam logic [2:0] S_WRESP = 3'd3;
   localparam logic [2:0] S_RBEAT = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;

   function automatic logic cmd_illegal(input logic [5:0] len,
                                        input logic [8:0] size,
                                        input logic [1:0] btyp);
      logic bad_size;
      logic bad_wrap;
      bad_size = !(size == 9'd1 || size == 9'd2 || size == 9'd4);
      bad_wrap = (btyp == BT_WRAP) &&
                 !(len == 6'd2 || len == 6'd4 || len == 6'd8 || len == 6'd16);
      return (len == 6'd0) || bad_size || (btyp == 2'd3) || bad_wrap;
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Beat address generator: holds the current beat address, loads the aligned
// start address and steps it per FIXED/INCR/WRAP rules.
module axi_burst_addr_gen
   import axi_arb_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          aclk,
   input  logic          resetn,
   input  logic [AW-1:0] addr_i,
   input  logic [8:0]    size_i,
   input  logic [5:0]    len_i,
   input  logic [1:0]    btyp_i,
   input  logic          load_i,
   input  logic          adv_i,
   output logic [AW-1:0] cur_o
);

   localparam logic [AW-1:0] ONE = 1;

   logic [AW-1:0] size_w, span_w, aligned, wrap_base, wrap_top, inc, nxt;
   logic [AW-1:0] cur_q, cur_d;

   // Masking is exact because size and span are powers of two whenever used.
   always_comb begin
      size_w    = AW'(size_i);
      span_w    = AW'(len_i) * size_w;
      aligned   = addr_i & ~(size_w - ONE);
      wrap_base = aligned & ~(span_w - ONE);
      wrap_top  = wrap_base + span_w;
      inc       = cur_q + size_w;
      case (btyp_i)
         BT_FIXED: nxt = aligned;
         BT_WRAP:  nxt = (inc >= wrap_top) ? wrap_base : inc;
         default:  nxt = inc;
      endcase
      cur_d = cur_q;
      if (load_i)     cur_d = aligned;
      else if (adv_i) cur_d = nxt;
   end

   always_ff @(posedge aclk) begin
      if (!resetn) cur_q <= '0;
      else         cur_q <= cur_d;
   end

   assign cur_o = cur_q;

endmodule

// File: rtl/axi_burst_arbiter.sv
// Round-robin two-requester front end that sequences AXI bursts beat by beat.
// Optional handshake watchdog enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_burst_arbiter
   import axi_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          aclk,
   input  logic          resetn,
   input  logic          r0_req,
   input  logic          r0_wr,
   input  logic [AW-1:0] r0_addr,
   input  logic [5:0]    r0_len,
   input  logic [8:0]    r0_size,
   input  logic [1:0]    r0_btyp,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_beat,
   output logic          r0_done,
   output logic          r0_err,
   input  logic          r1_req,
   input  logic          r1_wr,
   input  logic [AW-1:0] r1_addr,
   input  logic [5:0]    r1_len,
   input  logic [8:0]    r1_size,
   input  logic [1:0]    r1_btyp,
   input  logic [DW-1:0] r1_wdata,
   output logic          r1_beat,
   output logic          r1_done,
   output logic          r1_err,
   output logic [DW-1:0] rd_data,
   output logic          transfer,
   output logic [8:0]    bsize,
   output logic [5:0]    blen,
   output logic [1:0]    btyp,
   output logic          awvalid,
   output logic [AW-1:0] awadd,
   input  logic          awready,
   output logic          wvalid,
   output logic [DW-1:0] wdata,
   output logic          wlast,
   input  logic          wready,
   input  logic          bvalid,
   input  logic [1:0]    bresp,
   output logic          bready,
   output logic          arvalid,
   output logic [AW-1:0] aradd,
   input  logic          aready,
   input  logic          rvalid,
   input  logic [DW-1:0] rdata,
   input  logic          rlast,
   output logic          rready,
   output logic [2:0]    dbg_state_o
);

   // Handshakes: a write beat completes once awready and wready have each been
   // seen (same or different cycles) while valids are held; a read beat
   // completes in the cycle aready && rvalid; bvalid is accepted while bready.
   logic [2:0]    state_q, state_d;
   logic          rr_q, rr_d, gnt_q, gnt_d, wr_q, wr_d, err_q, err_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [5:0]    len_q, len_d, cnt_q, cnt_d;
   logic [8:0]    size_q, size_d;
   logic [1:0]    btyp_q, btyp_d;
   logic          aw_seen_q, aw_seen_d, w_seen_q, w_seen_d;
   logic          sel, last_beat, w_fire, r_fire, beat, tmo, in_w, in_r;
   logic [AW-1:0] cur;

   assign last_beat = (cnt_q == len_q - 6'd1);
   assign in_w      = (state_q == S_WBEAT);
   assign in_r      = (state_q == S_RBEAT);
   assign w_fire    = in_w && (awready || aw_seen_q) && (wready || w_seen_q);
   assign r_fire    = in_r && aready && rvalid;
   assign beat      = w_fire || r_fire;
   assign sel       = (r0_req && r1_req) ? rr_q : r1_req;

`ifdef AXI_ARB_TIMEOUT_EN
   logic [15:0] wd_q, wd_d;
   logic        waiting, progress;
   assign waiting  = in_w || in_r || (state_q == S_WRESP);
   assign progress = beat || ((state_q == S_WRESP) && bvalid);
   assign wd_d     = (waiting && !progress) ? wd_q + 16'd1 : 16'd0;
   assign tmo      = waiting && !progress && (wd_d == 16'(TIMEOUT));
   always_ff @(posedge aclk) begin
      if (!resetn) wd_q <= '0;
      else         wd_q <= wd_d;
   end
`else
   assign tmo = 1'b0;
`endif

   axi_burst_addr_gen #(.AW(AW)) u_addr_gen (
      .aclk   (aclk),
      .resetn (resetn),
      .addr_i (addr_q),
      .size_i (size_q),
      .len_i  (len_q),
      .btyp_i (btyp_q),
      .load_i (state_q == S_ARB),
      .adv_i  (beat),
      .cur_o  (cur)
   );

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      gnt_d     = gnt_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      btyp_d    = btyp_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      aw_seen_d = aw_seen_q;
      w_seen_d  = w_seen_q;
      case (state_q)
         S_IDLE: if (r0_req || r1_req) begin
            gnt_d   = sel;
            wr_d    = sel ? r1_wr   : r0_wr;
            addr_d  = sel ? r1_addr : r0_addr;
            len_d   = sel ? r1_len  : r0_len;
            size_d  = sel ? r1_size : r0_size;
            btyp_d  = sel ? r1_btyp : r0_btyp;
            err_d   = 1'b0;
            state_d = S_ARB;
         end
         S_ARB: begin
            cnt_d     = '0;
            aw_seen_d = 1'b0;
            w_seen_d  = 1'b0;
            if (cmd_illegal(len_q, size_q, btyp_q)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = wr_q ? S_WBEAT : S_RBEAT;
            end
         end
         S_WBEAT: begin
            if (bvalid && bresp != RESP_OKAY) err_d = 1'b1;
            if (w_fire) begin
               cnt_d     = cnt_q + 6'd1;
               aw_seen_d = 1'b0;
               w_seen_d  = 1'b0;
               if (last_beat) state_d = S_WRESP;
            end else begin
               aw_seen_d = aw_seen_q || awready;
               w_seen_d  = w_seen_q || wready;
            end
         end
         S_WRESP: if (bvalid) begin
            if (bresp != RESP_OKAY) err_d = 1'b1;
            state_d = S_DONE;
         end
         S_RBEAT: if (r_fire) begin
            cnt_d = cnt_q + 6'd1;
            if (rlast != last_beat) err_d = 1'b1;
            if (last_beat) state_d = S_DONE;
         end
         S_DONE: begin
            rr_d    = ~gnt_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (tmo) begin
         err_d   = 1'b1;
         state_d = S_DONE;
      end
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         rr_q      <= 1'b0;
         gnt_q     <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         btyp_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         aw_seen_q <= 1'b0;
         w_seen_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         gnt_q     <= gnt_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         btyp_q    <= btyp_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         aw_seen_q <= aw_seen_d;
         w_seen_q  <= w_seen_d;
      end
   end

   assign transfer    = (state_q == S_ARB) || in_w || in_r || (state_q == S_WRESP);
   assign bsize       = size_q;
   assign blen        = len_q;
   assign btyp        = btyp_q;
   assign awvalid     = in_w;
   assign wvalid      = in_w;
   assign awadd       = in_w ? cur : '0;
   assign wdata       = in_w ? (gnt_q ? r1_wdata : r0_wdata) : '0;
   assign wlast       = in_w && last_beat;
   assign bready      = (state_q == S_WRESP);
   assign arvalid     = in_r;
   assign aradd       = in_r ? cur : '0;
   assign rready      = in_r;
   assign rd_data     = r_fire ? rdata : '0;
   assign r0_beat     = beat && !gnt_q;
   assign r1_beat     = beat && gnt_q;
   assign r0_done     = (state_q == S_DONE) && !gnt_q;
   assign r1_done     = (state_q == S_DONE) && gnt_q;
   assign r0_err      = r0_done && err_q;
   assign r1_err      = r1_done && err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// Self-checking bench for axi_burst_arbiter: reactive slave model plus
// per-scenario tasks comparing observed beats against an expected queue.
module tb_axi_burst_arbiter;

   logic        aclk, resetn;
   logic        r0_req, r0_wr, r1_req, r1_wr;
   logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
   logic [5:0]  r0_len, r1_len;
   logic [8:0]  r0_size, r1_size;
   logic [1:0]  r0_btyp, r1_btyp;
   logic        r0_beat, r0_done, r0_err, r1_beat, r1_done, r1_err;
   logic [31:0] rd_data, awadd, wdata, aradd, rdata;
   logic        transfer, awvalid, awready, wvalid, wlast, wready;
   logic        bvalid, bready, arvalid, aready, rvalid, rlast, rready;
   logic [8:0]  bsize;
   logic [5:0]  blen;
   logic [1:0]  btyp, bresp;
   logic [2:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   // slave configuration and bookkeeping
   logic        aw_stuck = 1'b0;
   logic [1:0]  bresp_cfg = 2'd0;
   int          stall_beat = -1;
   int          stall_left = 0;
   int          s_wcnt = 0;
   int          s_rcnt = 0;

   // observation queues filled by run_burst
   logic [31:0] obs_addr_q[$], obs_data_q[$], stall_data_q[$];
   logic        obs_last_q[$];
   int          obs_beats, obs_done, obs_err, obs_valid, obs_cycles;
   logic [8:0]  obs_bsize;
   logic [5:0]  obs_blen;
   logic [1:0]  obs_btyp;
   logic        cfg_seen;

   // scoreboard
   logic [31:0] exp_q[$], expd_q[$];
   logic        expl_q[$];

   axi_burst_arbiter dut (
      .aclk(aclk), .resetn(resetn),
      .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_len(r0_len),
      .r0_size(r0_size), .r0_btyp(r0_btyp), .r0_wdata(r0_wdata),
      .r0_beat(r0_beat), .r0_done(r0_done), .r0_err(r0_err),
      .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_len(r1_len),
      .r1_size(r1_size), .r1_btyp(r1_btyp), .r1_wdata(r1_wdata),
      .r1_beat(r1_beat), .r1_done(r1_done), .r1_err(r1_err),
      .rd_data(rd_data), .transfer(transfer), .bsize(bsize), .blen(blen),
      .btyp(btyp), .awvalid(awvalid), .awadd(awadd), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wlast(wlast), .wready(wready),
      .bvalid(bvalid), .bresp(bresp), .bready(bready), .arvalid(arvalid),
      .aradd(aradd), .aready(aready), .rvalid(rvalid), .rdata(rdata),
      .rlast(rlast), .rready(rready), .dbg_state_o(dbg_state)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   function automatic logic [31:0] wd_pattern(input int who, input int i);
      return 32'hA000_0000 + (who << 16) + i;
   endfunction

   // reference beat address: offset arithmetic within the wrap window
   function automatic logic [31:0] model_addr(input logic [31:0] addr, input int len,
                                              input int size, input logic [1:0] bt, input int i);
      logic [31:0] al, span, base;
      al = addr - (addr % size);
      span = len * size;
      base = al - (al % span);
      case (bt)
         2'd0:    return al;
         2'd2:    return base + (((al - base) + i * size) % span);
         default: return al + i * size;
      endcase
   endfunction

   // reactive slave: decides inputs at each falling edge from DUT outputs
   initial begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      aready = 0; rvalid = 0; rdata = 0; rlast = 0;
      forever begin
         @(negedge aclk);
         awready = !aw_stuck;
         if (wvalid && s_wcnt == stall_beat && stall_left > 0) begin
            wready = 1'b0;
            stall_left--;
         end else begin
            wready = 1'b1;
         end
         if (!wvalid) s_wcnt = 0;
         else if (awready && wready) s_wcnt++;
         bvalid = bready;
         bresp  = bresp_cfg;
         aready = 1'b1;
         rvalid = arvalid;
         rdata  = arvalid ? mem_word(aradd) : 32'h0;
         rlast  = arvalid && (s_rcnt == int'(blen) - 1);
         if (arvalid) s_rcnt++;
         else s_rcnt = 0;
      end
   end

   task automatic apply_reset();
      @(negedge aclk);
      resetn = 1'b0;
      r0_req = 1'b0; r1_req = 1'b0;
      repeat (3) @(negedge aclk);
      resetn = 1'b1;
   endtask

   task automatic push_exp(input int who, input logic wr, input logic [31:0] addr,
                           input int len, input int size, input logic [1:0] bt);
      exp_q.delete(); expd_q.delete(); expl_q.delete();
      for (int i = 0; i < len; i++) begin
         logic [31:0] a;
         a = model_addr(addr, len, size, bt, i);
         exp_q.push_back(a);
         expd_q.push_back(wr ? wd_pattern(who, i) : mem_word(a));
         expl_q.push_back(i == len - 1);
      end
   endtask

   task automatic run_burst(input int who, input logic wr, input logic [31:0] addr,
                            input logic [5:0] len, input logic [8:0] size, input logic [1:0] bt);
      logic b, d;
      obs_addr_q.delete(); obs_data_q.delete(); obs_last_q.delete(); stall_data_q.delete();
      obs_beats = 0; obs_done = 0; obs_err = 0; obs_valid = 0; obs_cycles = 0; cfg_seen = 0;
      @(negedge aclk);
      if (who == 0) begin
         r0_wr = wr; r0_addr = addr; r0_len = len; r0_size = size; r0_btyp = bt;
         r0_wdata = wd_pattern(0, 0); r0_req = 1'b1;
      end else begin
         r1_wr = wr; r1_addr = addr; r1_len = len; r1_size = size; r1_btyp = bt;
         r1_wdata = wd_pattern(1, 0); r1_req = 1'b1;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge aclk); #2;
         obs_cycles++;
         if (transfer && !cfg_seen) begin
            cfg_seen = 1; obs_bsize = bsize; obs_blen = blen; obs_btyp = btyp;
         end
         if (awvalid || arvalid) obs_valid++;
         if (wvalid && !wready) stall_data_q.push_back(wdata);
         b = (who == 0) ? r0_beat : r1_beat;
         d = (who == 0) ? r0_done : r1_done;
         if (b) begin
            obs_addr_q.push_back(wr ? awadd : aradd);
            obs_data_q.push_back(wr ? wdata : rd_data);
            obs_last_q.push_back(wr ? wlast : 1'b0);
            obs_beats++;
            if (who == 0) r0_wdata = wd_pattern(0, obs_beats);
            else r1_wdata = wd_pattern(1, obs_beats);
         end
         if (d) begin
            obs_done = 1;
            obs_err = (who == 0) ? r0_err : r1_err;
            break;
         end
      end
      r0_req = 1'b0; r1_req = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #2;
      checks++;
      if ({transfer, bsize, blen, btyp, awvalid, awadd, wvalid, wdata, wlast, bready,
           arvalid, aradd, rready, rd_data, r0_beat, r0_done, r0_err,
           r1_beat, r1_done, r1_err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: some output nonzero, transfer=%b awvalid=%b arvalid=%b required all 0",
                  transfer, awvalid, arvalid);
      end
      checks++;
      if (dbg_state !== 3'd0) begin
         failures++;
         $display("FAIL reset_state: got %0d required 0", dbg_state);
      end
   endtask

   task automatic test_incr_write();
      push_exp(0, 1'b1, 32'h10, 4, 4, 2'd1);
      run_burst(0, 1'b1, 32'h10, 6'd4, 9'd4, 2'd1);
      checks++;
      if ({obs_bsize, obs_blen, obs_btyp} !== {9'd4, 6'd4, 2'd1}) begin
         failures++;
         $display("FAIL incr_cfg: got bsize=%0d blen=%0d btyp=%0d required 4/4/1",
                  obs_bsize, obs_blen, obs_btyp);
      end
      checks++;
      if (obs_beats != 4) begin
         failures++;
         $display("FAIL incr_beats: got %0d required 4", obs_beats);
      end
      while (exp_q.size() > 0 && obs_addr_q.size() > 0) begin
         logic [31:0] ea, ed, oa, od;
         logic el, ol;
         ea = exp_q.pop_front(); ed = expd_q.pop_front(); el = expl_q.pop_front();
         oa = obs_addr_q.pop_front(); od = obs_data_q.pop_front(); ol = obs_last_q.pop_front();
         checks++;
         if ({oa, od, ol} !== {ea, ed, el}) begin
            failures++;
            $display("FAIL incr_beat: got addr=%h data=%h last=%b required addr=%h data=%h last=%b",
                     oa, od, ol, ea, ed, el);
         end
      end
      checks++;
      if (obs_done != 1 || obs_err != 0) begin
         failures++;
         $display("FAIL incr_done: got done=%0d err=%0d required done=1 err=0", obs_done, obs_err);
      end
   endtask

   task automatic test_wrap_read();
      push_exp(1, 1'b0, 32'h18, 4, 4, 2'd2);
      run_burst(1, 1'b0, 32'h18, 6'd4, 9'd4, 2'd2);
      checks++;
      if (obs_beats != 4) begin
         failures++;
         $display("FAIL wrap_beats: got %0d required 4", obs_beats);
      end
      while (exp_q.size() > 0 && obs_addr_q.size() > 0) begin
         logic [31:0] ea, ed, oa, od;
         ea = exp_q.pop_front(); ed = expd_q.pop_front(); void'(expl_q.pop_front());
         oa = obs_addr_q.pop_front(); od = obs_data_q.pop_front(); void'(obs_last_q.pop_front());
         checks++;
         if ({oa, od} !== {ea, ed}) begin
            failures++;
            $display("FAIL wrap_beat: got aradd=%h rd_data=%h required aradd=%h rd_data=%h",
                     oa, od, ea, ed);
         end
      end
      checks++;
      if (obs_done != 1 || obs_err != 0) begin
         failures++;
         $display("FAIL wrap_done: got done=%0d err=%0d required done=1 err=0", obs_done, obs_err);
      end
   endtask

   task automatic test_arbitration();
      int order_q[$], exp_order_q[$];
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         exp_order_q.push_back(0);
         exp_order_q.push_back(1);
      end
      @(negedge aclk);
      r0_wr = 0; r0_addr = 32'h40; r0_len = 6'd2; r0_size = 9'd4; r0_btyp = 2'd1;
      r1_wr = 0; r1_addr = 32'h80; r1_len = 6'd2; r1_size = 9'd4; r1_btyp = 2'd1;
      r0_req = 1'b1; r1_req = 1'b1;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge aclk); #2;
         if (r0_done) order_q.push_back(0);
         if (r1_done) order_q.push_back(1);
         if (order_q.size() >= 6) break;
      end
      r0_req = 1'b0; r1_req = 1'b0;
      checks++;
      if (order_q.size() != 6) begin
         failures++;
         $display("FAIL arb_count: got %0d dones required 6", order_q.size());
      end
      while (order_q.size() > 0 && exp_order_q.size() > 0) begin
         int o, e;
         o = order_q.pop_front(); e = exp_order_q.pop_front();
         checks++;
         if (o != e) begin
            failures++;
            $display("FAIL arb_order: got r%0d required r%0d", o, e);
         end
      end
   endtask

   task automatic test_fixed_write();
      run_burst(0, 1'b1, 32'h23, 6'd3, 9'd4, 2'd0);
      checks++;
      if (obs_beats != 3) begin
         failures++;
         $display("FAIL fixed_beats: got %0d required 3", obs_beats);
      end
      while (obs_addr_q.size() > 0) begin
         logic [31:0] oa;
         oa = obs_addr_q.pop_front();
         checks++;
         if (oa !== 32'h20) begin
            failures++;
            $display("FAIL fixed_addr: got %h required 00000020", oa);
         end
      end
   endtask

   task automatic test_illegal();
      logic [5:0] lens[4]  = '{6'd3, 6'd0, 6'd4, 6'd4};
      logic [8:0] sizes[4] = '{9'd4, 9'd4, 9'd3, 9'd4};
      logic [1:0] bts[4]   = '{2'd2, 2'd1, 2'd1, 2'd3};
      for (int k = 0; k < 4; k++) begin
         run_burst(0, 1'b1, 32'h100, lens[k], sizes[k], bts[k]);
         checks++;
         if (obs_done != 1 || obs_err != 1) begin
            failures++;
            $display("FAIL illegal_done[%0d]: got done=%0d err=%0d required 1/1", k, obs_done, obs_err);
         end
         checks++;
         if (obs_valid != 0 || obs_beats != 0) begin
            failures++;
            $display("FAIL illegal_nobeat[%0d]: got valid_cycles=%0d beats=%0d required 0/0",
                     k, obs_valid, obs_beats);
         end
      end
   endtask

   task automatic test_bresp_err();
      bresp_cfg = 2'd2;
      run_burst(1, 1'b1, 32'h300, 6'd2, 9'd4, 2'd1);
      bresp_cfg = 2'd0;
      checks++;
      if (obs_done != 1 || obs_err != 1) begin
         failures++;
         $display("FAIL bresp_err: got done=%0d err=%0d required 1/1", obs_done, obs_err);
      end
   endtask

   task automatic test_wready_stall();
      stall_beat = 1; stall_left = 3;
      push_exp(0, 1'b1, 32'h200, 4, 4, 2'd1);
      run_burst(0, 1'b1, 32'h200, 6'd4, 9'd4, 2'd1);
      stall_beat = -1;
      checks++;
      if (obs_beats != 4 || stall_data_q.size() != 3) begin
         failures++;
         $display("FAIL stall_counts: got beats=%0d stall_cycles=%0d required 4/3",
                  obs_beats, stall_data_q.size());
      end
      while (stall_data_q.size() > 0) begin
         logic [31:0] sd;
         sd = stall_data_q.pop_front();
         checks++;
         if (sd !== wd_pattern(0, 1)) begin
            failures++;
            $display("FAIL stall_wdata: got %h required %h", sd, wd_pattern(0, 1));
         end
      end
      while (exp_q.size() > 0 && obs_addr_q.size() > 0) begin
         logic [31:0] ea, oa, ed, od;
         ea = exp_q.pop_front(); ed = expd_q.pop_front(); void'(expl_q.pop_front());
         oa = obs_addr_q.pop_front(); od = obs_data_q.pop_front(); void'(obs_last_q.pop_front());
         checks++;
         if ({oa, od} !== {ea, ed}) begin
            failures++;
            $display("FAIL stall_beat: got addr=%h data=%h required addr=%h data=%h", oa, od, ea, ed);
         end
      end
   endtask

   task automatic test_reset_mid();
      int dones, seen;
      seen = 0; dones = 0;
      @(negedge aclk);
      r0_wr = 1; r0_addr = 32'h100; r0_len = 6'd8; r0_size = 9'd4; r0_btyp = 2'd1;
      r0_wdata = wd_pattern(0, 0); r0_req = 1'b1;
      for (int cyc = 0; cyc < 100 && seen == 0; cyc++) begin
         @(negedge aclk); #2;
         if (r0_beat) seen = 1;
      end
      @(negedge aclk);
      resetn = 1'b0; r0_req = 1'b0;
      @(posedge aclk); #1;
      checks++;
      if ({transfer, awvalid, wvalid, awadd, wdata, wlast, bready, arvalid, rready,
           bsize, blen, btyp, r0_beat, r0_done, r0_err} !== '0 || seen == 0) begin
         failures++;
         $display("FAIL reset_mid_outputs: got transfer=%b awvalid=%b awadd=%h seen_beat=%0d required all 0 after beat",
                  transfer, awvalid, awadd, seen);
      end
      @(negedge aclk);
      resetn = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge aclk); #2;
         if (r0_done || r1_done) dones++;
      end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL reset_mid_nodone: got %0d done pulses required 0", dones);
      end
   endtask

   task automatic test_random();
      int sizes[3] = '{1, 2, 4};
      int wlens[4] = '{2, 4, 8, 16};
      for (int n = 0; n < 6; n++) begin
         int who, len, size;
         logic wr;
         logic [1:0] bt;
         logic [31:0] addr;
         who = $urandom_range(0, 1);
         wr = 1'($urandom_range(0, 1));
         bt = 2'($urandom_range(0, 2));
         size = sizes[$urandom_range(0, 2)];
         len = (bt == 2'd2) ? wlens[$urandom_range(0, 3)] : $urandom_range(1, 12);
         addr = $urandom_range(0, 32'hFFF);
         push_exp(who, wr, addr, len, size, bt);
         run_burst(who, wr, addr, 6'(len), 9'(size), bt);
         checks++;
         if (obs_beats != len || obs_done != 1 || obs_err != 0) begin
            failures++;
            $display("FAIL rand_burst[%0d]: got beats=%0d done=%0d err=%0d required %0d/1/0",
                     n, obs_beats, obs_done, obs_err, len);
         end
         while (exp_q.size() > 0 && obs_addr_q.size() > 0) begin
            logic [31:0] ea, ed, oa, od;
            ea = exp_q.pop_front(); ed = expd_q.pop_front(); void'(expl_q.pop_front());
            oa = obs_addr_q.pop_front(); od = obs_data_q.pop_front(); void'(obs_last_q.pop_front());
            checks++;
            if ({oa, od} !== {ea, ed}) begin
               failures++;
               $display("FAIL rand_beat[%0d]: got addr=%h data=%h required addr=%h data=%h",
                        n, oa, od, ea, ed);
            end
         end
      end
   endtask

`ifdef AXI_ARB_TIMEOUT_EN
   task automatic test_timeout();
      aw_stuck = 1'b1;
      run_burst(0, 1'b1, 32'h400, 6'd2, 9'd4, 2'd1);
      aw_stuck = 1'b0;
      checks++;
      if (obs_done != 1 || obs_err != 1 || obs_beats != 0 || obs_cycles < 64 || obs_cycles > 70) begin
         failures++;
         $display("FAIL timeout: got done=%0d err=%0d beats=%0d cycles=%0d required 1/1/0/~66",
                  obs_done, obs_err, obs_beats, obs_cycles);
      end
   endtask
`endif

   initial begin
      resetn = 1'b0;
      r0_req = 0; r0_wr = 0; r0_addr = 0; r0_len = 0; r0_size = 0; r0_btyp = 0; r0_wdata = 0;
      r1_req = 0; r1_wr = 0; r1_addr = 0; r1_len = 0; r1_size = 0; r1_btyp = 0; r1_wdata = 0;
      test_reset();
      test_incr_write();
      test_wrap_read();
      test_arbitration();
      test_fixed_write();
      test_illegal();
      test_bresp_err();
      test_wready_stall();
      test_random();
`ifdef AXI_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
